// File: rtl/fetch_prefetch_unit.sv
// Fetch stage: owns the PC, issues single-outstanding word requests to imem and
// buffers responses in a prefetch FIFO toward decode. Optional perf counters: FETCH_PERF_EN.

module fetch_prefetch_unit #(
  parameter int unsigned       DEPTH    = 4,
  parameter int unsigned       ADDR_W   = 64,
  parameter int unsigned       INSTR_W  = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               reset,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic               imem_gnt,
  input  logic               imem_rvalid,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic               instr_valid,
  output logic [INSTR_W-1:0] instr,
  output logic [ADDR_W-1:0]  instr_pc,
  input  logic               instr_ready,
  input  logic               redirect_valid,
  input  logic [ADDR_W-1:0]  redirect_pc,
  input  logic               halt,
  output logic               idle
`ifdef FETCH_PERF_EN
  , output logic [31:0]      perf_fetched
  , output logic [31:0]      perf_starve
`endif
);

  localparam int unsigned    PTR_W     = $clog2(DEPTH);
  localparam int unsigned    CNT_W     = PTR_W + 1;
  localparam logic [CNT_W:0] DEPTH_OCC = (CNT_W+1)'(DEPTH);

  typedef enum logic [1:0] {
    S_INIT  = 2'd0,
    S_FETCH = 2'd1,
    S_HALT  = 2'd2
  } state_e;

  state_e             state_q;
  logic [ADDR_W-1:0]  fetch_pc_q, fetch_pc_d;
  logic               inflight_q, inflight_d;
  logic [ADDR_W-1:0]  inflight_pc_q;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [INSTR_W-1:0] fifo_instr_q [DEPTH];
  logic [ADDR_W-1:0]  fifo_pc_q    [DEPTH];

  logic               fifo_empty;
  logic               credit_ok;
  logic               grant;
  logic               push;
  logic               pop;
  logic [CNT_W:0]     occupancy;
  logic [ADDR_W-1:0]  redirect_target;
  logic               redirect_lsb_unused;

  assign redirect_target     = {redirect_pc[ADDR_W-1:2], 2'b00};
  assign redirect_lsb_unused = ^redirect_pc[1:0];

  // Buffered plus in-flight entries may never exceed DEPTH, so a push always finds room.
  assign fifo_empty = (count_q == '0);
  assign occupancy  = {1'b0, count_q} + {{CNT_W{1'b0}}, inflight_q};
  assign credit_ok  = (occupancy < DEPTH_OCC);

  assign imem_req  = (state_q == S_FETCH) && !halt && !redirect_valid && credit_ok;
  assign imem_addr = fetch_pc_q;
  assign grant     = imem_req && imem_gnt;

  // A response counts only while a request is outstanding; a redirect kills it.
  assign push        = imem_rvalid && inflight_q && !redirect_valid;
  assign instr_valid = !fifo_empty && !redirect_valid;
  assign pop         = instr_valid && instr_ready;
  assign instr       = fifo_empty ? '0 : fifo_instr_q[rd_ptr_q];
  assign instr_pc    = fifo_empty ? '0 : fifo_pc_q[rd_ptr_q];
  assign idle        = (state_q == S_HALT);

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    fetch_pc_d = fetch_pc_q;
    inflight_d = inflight_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    if (redirect_valid) begin
      fetch_pc_d = redirect_target;
      inflight_d = 1'b0;
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      count_d    = '0;
    end else begin
      if (grant) begin
        fetch_pc_d = fetch_pc_q + ADDR_W'(4);
        inflight_d = 1'b1;
      end else if (imem_rvalid) begin
        inflight_d = 1'b0;
      end
      if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      count_d = count_q + CNT_W'(push) - CNT_W'(pop);
    end
  end

  // NOTE: sequential state is assigned with <= so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc_q    <= RESET_PC;
      inflight_q    <= 1'b0;
      inflight_pc_q <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      inflight_q <= inflight_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      if (grant) inflight_pc_q <= fetch_pc_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_INIT;
    end else begin
      unique case (state_q)
        S_INIT:  state_q <= S_FETCH;
        S_FETCH: if (halt && !inflight_q) state_q <= S_HALT;
        S_HALT:  if (!halt) state_q <= S_FETCH;
        default: state_q <= S_INIT;
      endcase
    end
  end

  // NOTE: FIFO storage has no reset; count_q alone decides validity and outputs are gated on empty.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_instr_q[wr_ptr_q] <= imem_rdata;
      fifo_pc_q[wr_ptr_q]    <= inflight_pc_q;
    end
  end

`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetched_q;
  logic [31:0] perf_starve_q;
  logic        starve;

  assign starve = (state_q == S_FETCH) && fifo_empty && instr_ready;

  // Saturating counters; redirects deliberately leave them alone.
  always_ff @(posedge clk) begin
    if (reset) begin
      perf_fetched_q <= '0;
      perf_starve_q  <= '0;
    end else begin
      if (pop && (perf_fetched_q != '1))   perf_fetched_q <= perf_fetched_q + 32'd1;
      if (starve && (perf_starve_q != '1)) perf_starve_q  <= perf_starve_q + 32'd1;
    end
  end

  assign perf_fetched = perf_fetched_q;
  assign perf_starve  = perf_starve_q;
`endif

endmodule

// File: tb/tb_fetch_prefetch_unit.sv
// Bench for fetch_prefetch_unit: directed scenarios plus randomized traffic, checked by a
// scoreboard whose model is "decode sees consecutive PCs from the last restart point".

module tb_fetch_prefetch_unit;

  localparam int DEPTH   = 4;
  localparam int ADDR_W  = 64;
  localparam int INSTR_W = 32;

  logic               clk;
  logic               reset;
  logic               imem_req;
  logic [ADDR_W-1:0]  imem_addr;
  logic               imem_gnt;
  logic               imem_rvalid;
  logic [INSTR_W-1:0] imem_rdata;
  logic               instr_valid;
  logic [INSTR_W-1:0] instr;
  logic [ADDR_W-1:0]  instr_pc;
  logic               instr_ready;
  logic               redirect_valid;
  logic [ADDR_W-1:0]  redirect_pc;
  logic               halt;
  logic               idle;
`ifdef FETCH_PERF_EN
  logic [31:0]        perf_fetched;
  logic [31:0]        perf_starve;
`endif

  fetch_prefetch_unit #(
    .DEPTH    (DEPTH),
    .ADDR_W   (ADDR_W),
    .INSTR_W  (INSTR_W),
    .RESET_PC (64'h0)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_gnt       (imem_gnt),
    .imem_rvalid    (imem_rvalid),
    .imem_rdata     (imem_rdata),
    .instr_valid    (instr_valid),
    .instr          (instr),
    .instr_pc       (instr_pc),
    .instr_ready    (instr_ready),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .halt           (halt),
    .idle           (idle)
`ifdef FETCH_PERF_EN
    , .perf_fetched (perf_fetched)
    , .perf_starve  (perf_starve)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int pops   = 0;

  logic [63:0] exp_q[$];
  logic [63:0] model_pc;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Memory content is a fixed hash of the word address.
  function automatic logic [31:0] mem_word(input logic [63:0] a);
    logic [31:0] h;
    h = a[31:0] ^ a[63:32];
    return (h * 32'h9E37_79B1) ^ 32'h00C0_FFEE;
  endfunction

  task automatic topup();
    while (exp_q.size() < 8) begin
      exp_q.push_back(model_pc);
      model_pc += 64'd4;
    end
  endtask

  task automatic flush_model(input logic [63:0] target);
    exp_q.delete();
    model_pc = {target[63:2], 2'b00};
    topup();
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    topup();
  endtask

  // Memory: a grant seen in one cycle is answered in the next.
  initial begin
    logic        g;
    logic [63:0] a;
    imem_rvalid = 1'b0;
    imem_rdata  = '0;
    forever begin
      @(negedge clk);
      g = imem_req && imem_gnt;
      a = imem_addr;
      @(posedge clk);
      #1;
      imem_rvalid = g;
      imem_rdata  = g ? mem_word(a) : $urandom();
    end
  end

  // Monitor: compares every pop against the scoreboard and checks head stability.
  initial begin
    logic        prev_stall;
    logic [63:0] prev_pc;
    logic [31:0] prev_instr;
    logic [63:0] e;
    prev_stall = 1'b0;
    prev_pc    = '0;
    prev_instr = '0;
    forever begin
      @(negedge clk);
      if (reset) begin
        prev_stall = 1'b0;
        continue;
      end
      if (redirect_valid) begin
        check("valid_during_redirect", 64'(instr_valid), 64'd0);
        prev_stall = 1'b0;
        continue;
      end
      if (prev_stall) begin
        check("hold_valid", 64'(instr_valid), 64'd1);
        check("hold_pc", instr_pc, prev_pc);
        check("hold_instr", 64'(instr), 64'(prev_instr));
      end
      if (instr_valid && instr_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL pop_unexpected: got pc 0x%0h, expected no pop", instr_pc);
        end else begin
          e = exp_q.pop_front();
          check("pop_pc", instr_pc, e);
          check("pop_instr", 64'(instr), 64'(mem_word(e)));
          pops++;
        end
      end
      prev_stall = instr_valid && !instr_ready;
      prev_pc    = instr_pc;
      prev_instr = instr;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog expired");
  end

  int          grants;
  int          p0;
  int          halt_left;
  int          r;
  logic        found;
  logic [63:0] faddr;
  logic [63:0] exp_addr;

  initial begin
    reset          = 1'b1;
    imem_gnt       = 1'b1;
    instr_ready    = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    halt           = 1'b0;
    flush_model(64'h0);

    // Reset values, then streaming with grant and ready tied high.
    repeat (3) step();
    @(negedge clk);
    check("reset_req", 64'(imem_req), 64'd0);
    check("reset_addr", imem_addr, 64'h0);
    check("reset_valid", 64'(instr_valid), 64'd0);
    check("reset_instr", 64'(instr), 64'd0);
    check("reset_instr_pc", instr_pc, 64'h0);
    check("reset_idle", 64'(idle), 64'd0);
`ifdef FETCH_PERF_EN
    check("reset_perf_fetched", 64'(perf_fetched), 64'd0);
    check("reset_perf_starve", 64'(perf_starve), 64'd0);
`endif
    step();
    reset = 1'b0;
    @(negedge clk);
    check("init_no_req", 64'(imem_req), 64'd0);
    step();
    @(negedge clk);
    check("first_req", 64'(imem_req), 64'd1);
    check("first_addr", imem_addr, 64'h0);
    #1;
    p0 = pops;
    repeat (30) begin
      step();
      @(negedge clk);
    end
    #1;
    check("stream_rate", 64'(pops - p0), 64'd29);

    // Backpressure: the FIFO fills with exactly DEPTH grants.
    step();
    reset       = 1'b1;
    instr_ready = 1'b0;
    flush_model(64'h0);
    repeat (2) step();
    reset  = 1'b0;
    grants = 0;
    repeat (12) begin
      @(negedge clk);
      if (imem_req && imem_gnt) grants++;
      step();
    end
    @(negedge clk);
    check("bp_grants", 64'(grants), 64'(DEPTH));
    check("bp_req_low", 64'(imem_req), 64'd0);
    check("bp_valid", 64'(instr_valid), 64'd1);
    check("bp_head_pc", instr_pc, 64'h0);
    check("bp_head_instr", 64'(instr), 64'(mem_word(64'h0)));
    step();
    instr_ready = 1'b1;
    found = 1'b0;
    faddr = '0;
    for (int i = 0; i < 6 && !found; i++) begin
      @(negedge clk);
      if (imem_req) begin
        found = 1'b1;
        faddr = imem_addr;
      end else begin
        step();
      end
    end
    check("bp_resume_seen", 64'(found), 64'd1);
    check("bp_resume_addr", faddr, 64'h10);

    // Redirect while 3 entries are buffered and a response is landing.
    step();
    reset       = 1'b1;
    instr_ready = 1'b0;
    flush_model(64'h0);
    repeat (2) step();
    reset = 1'b0;
    repeat (5) step();
    redirect_valid = 1'b1;
    redirect_pc    = 64'h103;
    flush_model(64'h103);
    @(negedge clk);
    check("redir_no_req", 64'(imem_req), 64'd0);
    step();
    redirect_valid = 1'b0;
    instr_ready    = 1'b1;
    @(negedge clk);
    check("redir_req", 64'(imem_req), 64'd1);
    check("redir_addr", imem_addr, 64'h100);
    check("redir_flushed", 64'(instr_valid), 64'd0);
    #1;
    p0 = pops;
    repeat (4) step();
    @(negedge clk);
    #1;
    check("redir_pop_seen", 64'(pops > p0), 64'd1);

    // Grant stall at 0x20: request and address must hold.
    step();
    redirect_valid = 1'b1;
    redirect_pc    = 64'h20;
    imem_gnt       = 1'b0;
    flush_model(64'h20);
    step();
    redirect_valid = 1'b0;
    repeat (5) begin
      @(negedge clk);
      check("stall_req", 64'(imem_req), 64'd1);
      check("stall_addr", imem_addr, 64'h20);
      step();
    end
    imem_gnt = 1'b1;
    @(negedge clk);
    check("stall_grant_addr", imem_addr, 64'h20);
    step();
    @(negedge clk);
    check("stall_next_addr", imem_addr, 64'h24);

    // Halt mid-stream: requests stop, FIFO drains, idle after the in-flight lands.
    repeat (5) step();
    halt = 1'b1;
    @(negedge clk);
    check("halt_first_req", 64'(imem_req), 64'd0);
    check("halt_not_idle_yet", 64'(idle), 64'd0);
    repeat (8) begin
      step();
      @(negedge clk);
      check("halt_req_low", 64'(imem_req), 64'd0);
    end
    check("halt_idle", 64'(idle), 64'd1);
    check("halt_drained", 64'(instr_valid), 64'd0);
    step();
    halt     = 1'b0;
    exp_addr = exp_q[0];
    found    = 1'b0;
    faddr    = '0;
    for (int i = 0; i < 4 && !found; i++) begin
      @(negedge clk);
      if (imem_req) begin
        found = 1'b1;
        faddr = imem_addr;
      end else begin
        step();
      end
    end
    check("halt_resume_seen", 64'(found), 64'd1);
    check("halt_resume_addr", faddr, exp_addr);

`ifdef FETCH_PERF_EN
    // 8 pops and 3 starved cycles, then a redirect that must not touch the counters.
    step();
    reset       = 1'b1;
    instr_ready = 1'b0;
    imem_gnt    = 1'b1;
    flush_model(64'h0);
    repeat (2) step();
    reset = 1'b0;
    repeat (10) step();
    imem_gnt    = 1'b0;
    instr_ready = 1'b1;
    repeat (7) step();
    instr_ready = 1'b0;
    imem_gnt    = 1'b1;
    repeat (10) step();
    instr_ready = 1'b1;
    imem_gnt    = 1'b0;
    repeat (4) step();
    instr_ready = 1'b0;
    imem_gnt    = 1'b1;
    @(negedge clk);
    check("perf_fetched", 64'(perf_fetched), 64'd8);
    check("perf_starve", 64'(perf_starve), 64'd3);
    step();
    redirect_valid = 1'b1;
    redirect_pc    = 64'h400;
    flush_model(64'h400);
    step();
    redirect_valid = 1'b0;
    @(negedge clk);
    check("perf_fetched_redir", 64'(perf_fetched), 64'd8);
    check("perf_starve_redir", 64'(perf_starve), 64'd3);
`endif

    // Randomized traffic: ready/grant jitter, halt bursts, redirects (incl. wrap), resets.
    step();
    reset          = 1'b1;
    halt           = 1'b0;
    redirect_valid = 1'b0;
    flush_model(64'h0);
    repeat (2) step();
    reset     = 1'b0;
    halt_left = 0;
    p0        = pops;
    for (int c = 0; c < 3000; c++) begin
      step();
      redirect_valid = 1'b0;
      reset          = 1'b0;
      instr_ready    = ($urandom_range(0, 3) != 0);
      imem_gnt       = ($urandom_range(0, 4) != 0);
      if (halt_left > 0) halt_left--;
      else if ($urandom_range(0, 60) == 0) halt_left = int'($urandom_range(1, 12));
      halt = (halt_left > 0);
      r = int'($urandom_range(0, 199));
      if (r < 8) begin
        redirect_valid = 1'b1;
        redirect_pc    = (r == 0) ? 64'hFFFF_FFFF_FFFF_FFF5 : {$urandom(), $urandom()};
        flush_model(redirect_pc);
      end else if (r == 8) begin
        reset = 1'b1;
        flush_model(64'h0);
      end
    end
    step();
    reset          = 1'b0;
    redirect_valid = 1'b0;
    halt           = 1'b0;
    instr_ready    = 1'b1;
    imem_gnt       = 1'b1;
    repeat (20) step();
    check("random_progress", 64'(pops - p0 > 500), 64'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
